// File: rtl/photons_deadlock_watchdog.sv
// Deadlock watchdog for the photon MAXI capture path: filters monitor block
// indications by persistence, reports each trip once over valid/ready and raises a sticky irq.
module photons_deadlock_watchdog #(
    parameter int NUM_MON = 4,
    parameter int CNT_W   = 16,
    parameter int TRIP_W  = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [CNT_W-1:0]   threshold,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic               all_idle,
    input  logic               clear,
    output logic               dl_valid,
    input  logic               dl_ready,
    output logic [NUM_MON-1:0] dl_source,
    output logic [CNT_W-1:0]   dl_cycles,
    output logic               irq,
    output logic [TRIP_W-1:0]  trip_count,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        PENDING = 3'd2,
        REPORT  = 3'd3,
        LATCHED = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_MON-1:0] mask_q, mask_d;
    logic [NUM_MON-1:0] src_q, src_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic               irq_q, irq_d;
    logic [TRIP_W-1:0]  trip_q, trip_d;

    logic               qblk;
    logic [CNT_W-1:0]   thr_eff;
    logic [CNT_W:0]     cnt_inc;
    logic               trip_now;

    assign qblk    = (|mon_block) & ~all_idle & enable;
    assign thr_eff = (threshold == '0) ? CNT_W'(1) : threshold;
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            src_q   <= '0;
            cyc_q   <= '0;
            irq_q   <= 1'b0;
            trip_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            src_q   <= src_d;
            cyc_q   <= cyc_d;
            irq_q   <= irq_d;
            trip_q  <= trip_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        src_d    = src_q;
        cyc_d    = cyc_q;
        irq_d    = irq_q;
        trip_d   = trip_q;
        trip_now = 1'b0;

        if (clear && state_q != LATCHED) begin
            irq_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                mask_d = '0;
                if (enable) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                cnt_d  = '0;
                mask_d = '0;
                if (!enable) begin
                    state_d = IDLE;
                end else if (clear) begin
                    state_d = ARMED;
                end else if (qblk) begin
                    if (thr_eff == CNT_W'(1)) begin
                        trip_now = 1'b1;
                        src_d    = mon_block;
                        cyc_d    = CNT_W'(1);
                    end else begin
                        state_d = PENDING;
                        cnt_d   = CNT_W'(1);
                        mask_d  = mon_block;
                    end
                end
            end
            PENDING: begin
                if (!enable || clear || !qblk) begin
                    state_d = enable ? ARMED : IDLE;
                    cnt_d   = '0;
                    mask_d  = '0;
                end else if (cnt_inc >= {1'b0, thr_eff}) begin
                    // >= rather than == so a threshold lowered mid-episode trips at once
                    trip_now = 1'b1;
                    src_d    = mask_q | mon_block;
                    cyc_d    = cnt_inc[CNT_W-1:0];
                    cnt_d    = '0;
                    mask_d   = '0;
                end else begin
                    cnt_d  = cnt_inc[CNT_W-1:0];
                    mask_d = mask_q | mon_block;
                end
            end
            REPORT: begin
                if (dl_ready) begin
                    state_d = LATCHED;
                end
            end
            LATCHED: begin
                if (clear) begin
                    state_d = enable ? ARMED : IDLE;
                    irq_d   = 1'b0;
                    cnt_d   = '0;
                    mask_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                mask_d  = '0;
            end
        endcase

        if (trip_now) begin
            state_d = REPORT;
            irq_d   = 1'b1;
            if (trip_q != '1) begin
                trip_d = trip_q + TRIP_W'(1);
            end
        end
    end

    assign dl_valid   = (state_q == REPORT);
    assign dl_source  = src_q;
    assign dl_cycles  = cyc_q;
    assign irq        = irq_q;
    assign trip_count = trip_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_photons_deadlock_watchdog.sv
// Directed bench for photons_deadlock_watchdog; reports are scored against a queue
// of expected {source, cycles} pairs filled as each trip is provoked.
module tb_photons_deadlock_watchdog;

    localparam int NUM_MON = 4;
    localparam int CNT_W   = 16;
    localparam int TRIP_W  = 8;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               enable;
    logic [CNT_W-1:0]   threshold;
    logic [NUM_MON-1:0] mon_block;
    logic               all_idle;
    logic               clear;
    logic               dl_valid;
    logic               dl_ready;
    logic [NUM_MON-1:0] dl_source;
    logic [CNT_W-1:0]   dl_cycles;
    logic               irq;
    logic [TRIP_W-1:0]  trip_count;
    logic [2:0]         state_o;

    int asserts  = 0;
    int failures = 0;

    logic [NUM_MON+CNT_W-1:0] exp_q[$];

    photons_deadlock_watchdog #(.NUM_MON(NUM_MON), .CNT_W(CNT_W), .TRIP_W(TRIP_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .threshold  (threshold),
        .mon_block  (mon_block),
        .all_idle   (all_idle),
        .clear      (clear),
        .dl_valid   (dl_valid),
        .dl_ready   (dl_ready),
        .dl_source  (dl_source),
        .dl_cycles  (dl_cycles),
        .irq        (irq),
        .trip_count (trip_count),
        .state_o    (state_o)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [CNT_W-1:0] thr,
                                 input logic [NUM_MON-1:0] mb, input logic idle,
                                 input logic clr, input logic rdy);
        enable    = en;
        threshold = thr;
        mon_block = mb;
        all_idle  = idle;
        clear     = clr;
        dl_ready  = rdy;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pushExpected(input logic [NUM_MON-1:0] src, input logic [CNT_W-1:0] cyc);
        exp_q.push_back({src, cyc});
    endtask

    // Score every accepted report against the oldest outstanding expectation
    always @(negedge clock) begin
        if (dl_valid === 1'b1 && dl_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_report", {12'd0, dl_source, dl_cycles}, 32'hFFFF_FFFF);
            end else begin
                logic [NUM_MON+CNT_W-1:0] e;
                e = exp_q.pop_front();
                checkOutput("sb_source", 32'(dl_source), 32'(e[NUM_MON+CNT_W-1:CNT_W]));
                checkOutput("sb_cycles", 32'(dl_cycles), 32'(e[CNT_W-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int valid_seen;
        logic [NUM_MON-1:0] alt;

        reset_n = 1'b0;
        applyStimulus(1'b0, 16'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        #12;
        checkOutput("rst_valid", 32'(dl_valid), 0);
        checkOutput("rst_irq", 32'(irq), 0);
        checkOutput("rst_trip", 32'(trip_count), 0);
        checkOutput("rst_state", 32'(state_o), 0);
        checkOutput("rst_source", 32'(dl_source), 0);
        checkOutput("rst_cycles", 32'(dl_cycles), 0);
        tick(1);
        reset_n = 1'b1;

        // Basic trip at threshold 5
        $display("[TB] test 1: threshold 5 latency");
        applyStimulus(1'b1, 16'd5, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("t1_armed", 32'(state_o), 1);
        applyStimulus(1'b1, 16'd5, 4'b0001, 1'b0, 1'b0, 1'b0);
        pushExpected(4'b0001, 16'd5);
        tick(4);
        checkOutput("t1_not_yet", 32'(dl_valid), 0);
        tick(1);
        checkOutput("t1_valid", 32'(dl_valid), 1);
        checkOutput("t1_irq", 32'(irq), 1);
        checkOutput("t1_trip", 32'(trip_count), 1);
        checkOutput("t1_source", 32'(dl_source), 32'b0001);
        checkOutput("t1_cycles", 32'(dl_cycles), 5);
        tick(5);
        applyStimulus(1'b1, 16'd5, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("t1_latched", 32'(state_o), 4);
        checkOutput("t1_valid_drop", 32'(dl_valid), 0);
        applyStimulus(1'b1, 16'd5, 4'b0000, 1'b0, 1'b1, 1'b0);
        tick(1);
        checkOutput("t1_cleared_state", 32'(state_o), 1);
        checkOutput("t1_cleared_irq", 32'(irq), 0);

        // Interrupted burst must not accumulate into the next one
        $display("[TB] test 2: interrupted burst");
        applyStimulus(1'b1, 16'd8, 4'b0010, 1'b0, 1'b0, 1'b0);
        tick(3);
        applyStimulus(1'b1, 16'd8, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("t2_back_armed", 32'(state_o), 1);
        applyStimulus(1'b1, 16'd8, 4'b0100, 1'b0, 1'b0, 1'b0);
        pushExpected(4'b0100, 16'd8);
        tick(7);
        checkOutput("t2_not_yet", 32'(dl_valid), 0);
        tick(1);
        checkOutput("t2_valid", 32'(dl_valid), 1);
        checkOutput("t2_source", 32'(dl_source), 32'b0100);
        checkOutput("t2_cycles", 32'(dl_cycles), 8);
        checkOutput("t2_trip", 32'(trip_count), 2);
        applyStimulus(1'b1, 16'd8, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b1, 16'd8, 4'b0000, 1'b0, 1'b1, 1'b0);
        tick(1);

        // Alternating monitors, report held under back-pressure
        $display("[TB] test 3: back-pressure hold");
        alt = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'd4, alt, 1'b0, 1'b0, 1'b0);
            if (i == 0) pushExpected(4'b1001, 16'd4);
            tick(1);
            alt = (alt == 4'b0001) ? 4'b1000 : 4'b0001;
        end
        for (int i = 0; i < 6; i++) begin
            checkOutput("t3_hold_valid", 32'(dl_valid), 1);
            checkOutput("t3_hold_source", 32'(dl_source), 32'b1001);
            checkOutput("t3_hold_cycles", 32'(dl_cycles), 4);
            applyStimulus(1'b1, 16'd4, alt, 1'b0, 1'b0, 1'b0);
            tick(1);
            alt = (alt == 4'b0001) ? 4'b1000 : 4'b0001;
        end
        applyStimulus(1'b1, 16'd4, alt, 1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("t3_latched", 32'(state_o), 4);
        checkOutput("t3_valid_drop", 32'(dl_valid), 0);
        applyStimulus(1'b1, 16'd4, 4'b1111, 1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("t3_still_latched", 32'(state_o), 4);
        checkOutput("t3_irq_sticky", 32'(irq), 1);
        applyStimulus(1'b1, 16'd4, 4'b1111, 1'b0, 1'b1, 1'b0);
        tick(1);
        checkOutput("t3_clear_armed", 32'(state_o), 1);
        checkOutput("t3_clear_irq", 32'(irq), 0);
        applyStimulus(1'b1, 16'd4, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("t3_rearmed", 32'(state_o), 1);

        // Threshold 0 behaves as 1; ready on entry gives a one-cycle report
        $display("[TB] test 4: threshold zero and idle suppression");
        applyStimulus(1'b1, 16'd0, 4'b0001, 1'b0, 1'b0, 1'b1);
        pushExpected(4'b0001, 16'd1);
        tick(1);
        checkOutput("t4_valid", 32'(dl_valid), 1);
        checkOutput("t4_cycles", 32'(dl_cycles), 1);
        applyStimulus(1'b1, 16'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("t4_one_cycle", 32'(dl_valid), 0);
        checkOutput("t4_latched", 32'(state_o), 4);
        applyStimulus(1'b1, 16'd0, 4'b0000, 1'b0, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 16'd0, 4'b0001, 1'b0, 1'b1, 1'b1);
        pushExpected(4'b0001, 16'd1);
        tick(1);
        checkOutput("t4_clear_wins", 32'(state_o), 1);
        applyStimulus(1'b1, 16'd0, 4'b0001, 1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("t4_deferred_trip", 32'(state_o), 3);
        applyStimulus(1'b1, 16'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b1, 16'd0, 4'b0000, 1'b0, 1'b1, 1'b1);
        tick(1);
        checkOutput("t4_trip_count", 32'(trip_count), 5);
        valid_seen = 0;
        applyStimulus(1'b1, 16'd0, 4'b1111, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (dl_valid === 1'b1) valid_seen++;
        end
        checkOutput("t4_idle_no_trip", 32'(valid_seen), 0);
        checkOutput("t4_idle_state", 32'(state_o), 1);

        // Saturation of the trip counter
        $display("[TB] test 5: trip counter saturation and async reset");
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 16'd0, 4'b0001, 1'b0, 1'b0, 1'b1);
            pushExpected(4'b0001, 16'd1);
            tick(1);
            applyStimulus(1'b1, 16'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
            tick(1);
            applyStimulus(1'b1, 16'd0, 4'b0000, 1'b0, 1'b1, 1'b1);
            tick(1);
            if (i == 100) checkOutput("t5_trip_mid", 32'(trip_count), 106);
        end
        checkOutput("t5_trip_sat", 32'(trip_count), 255);

        applyStimulus(1'b1, 16'd10, 4'b0001, 1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("t5_pending", 32'(state_o), 2);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", 32'(dl_valid), 0);
        checkOutput("t5_rst_irq", 32'(irq), 0);
        checkOutput("t5_rst_trip", 32'(trip_count), 0);
        checkOutput("t5_rst_state", 32'(state_o), 0);
        checkOutput("t5_rst_source", 32'(dl_source), 0);
        checkOutput("t5_rst_cycles", 32'(dl_cycles), 0);
        applyStimulus(1'b0, 16'd10, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        checkOutput("t5_post_idle", 32'(state_o), 0);

        checkOutput("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
